pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Stall/flush sequencer for the 5-stage pipeline. Drives write-enables and flush
//  (bubble) controls of PC, IF/ID, ID/EX and EX/MEM registers. Detects load-use
//  hazards, applies taken-branch flushes resolved in MEM, and tracks a multi-cycle
//  MUL/DIV unit, stalling dependent instructions in ID until HI/LO is ready.
// PARAMETERS
//  MD_LAT  32  MUL/DIV latency in cycles from MD_Start to result valid (>=2)
//  CNT_W   6   counter width; must satisfy 2**CNT_W > MD_LAT
// PORTS
//  Clk          in   1   clock, all state updates on posedge
//  Rst          in   1   synchronous, active-high reset
//  Id_Rs        in   5   rs field of instruction in ID
//  Id_Rt        in   5   rt field of instruction in ID
//  Id_UseRs     in   1   ID instruction reads rs
//  Id_UseRt     in   1   ID instruction reads rt
//  Id_MdUse     in   1   ID instruction is MUL/DIV or reads HI/LO (mfhi/mflo)
//  Ex_MemRead   in   2   load size of EX instruction; 2'b00 = not a load
//  Ex_Rw        in   5   destination register of EX instruction
//  Ex_MdOp      in   1   EX instruction is MUL/DIV
//  Mem_BrTaken  in   1   branch/jump in MEM resolved taken
//  PC_Wr        out  1   PC load enable
//  IfId_Wr      out  1   IF/ID load enable
//  IfId_Flush   out  1   IF/ID loads zero (nop)
//  IdEx_Flush   out  1   ID/EX loads zero (bubble)
//  ExMem_Flush  out  1   EX/MEM loads zero (bubble)
//  MD_Start     out  1   one-cycle start pulse to MUL/DIV unit
//  MD_Busy      out  1   MUL/DIV result not yet valid
// BEHAVIOUR
//  State: st in {RUN, BUSY}; cnt[CNT_W-1:0]. Control outputs combinational from
//  inputs + state. Clock Clk, reset Rst: synchronous, active-high.
//  Rst high: st<=RUN, cnt<=0; outputs PC_Wr=0, IfId_Wr=0, all three Flush=1,
//   MD_Start=0, MD_Busy=0. Rst mid-BUSY abandons the operation.
//  Default (no hazard): PC_Wr=1, IfId_Wr=1, all Flush=0.
//  ld_haz = (Ex_MemRead!=0) & (Ex_Rw!=0) &
//   ((Id_UseRs & Id_Rs==Ex_Rw) | (Id_UseRt & Id_Rt==Ex_Rw)).
//  md_haz = (st==BUSY) & Id_MdUse.
//  Priority Rst > branch > md_haz > ld_haz:
//   Mem_BrTaken: PC_Wr=1 (target), IfId_Wr=1, IfId_Flush=IdEx_Flush=ExMem_Flush=1.
//   md_haz or ld_haz: PC_Wr=0, IfId_Wr=0, IdEx_Flush=1, others 0.
//  ld_haz lasts exactly 1 cycle (load advances to MEM; forwarding covers rest).
//  MD_Start = (st==RUN) & Ex_MdOp & ~Mem_BrTaken & ~Rst (wrong-path op never starts).
//  RUN->BUSY on MD_Start, cnt<=MD_LAT-1. BUSY: cnt<=cnt-1 each cycle;
//   cnt==1 -> st<=RUN, cnt<=0. Total BUSY cycles = MD_LAT-1; HI/LO valid
//   MD_LAT cycles after the MD_Start cycle.
//  MD_Busy = (st==BUSY) (registered). Mem_BrTaken during BUSY does not abort:
//   in-flight MUL/DIV is older than the branch.
//  Ex_MdOp while BUSY is illegal (md_haz prevents it); ignored, no restart.
//  md_haz releases in the cycle st returns to RUN (zero extra bubble).
// TESTING
//  1 Rst=1 two cycles -> PC_Wr=0,IfId_Wr=0,all Flush=1,MD_Busy=0; release -> PC_Wr=1.
//  2 Ex_MemRead=2'b11,Ex_Rw=8; Id_Rs=8,Id_UseRs=1 -> 1 cycle PC_Wr=0,IdEx_Flush=1;
//    Ex_Rw=0 same pattern -> no stall.
//  3 Mem_BrTaken=1 with ld_haz=1 -> PC_Wr=1, all three Flush=1; no stall.
//  4 MD_LAT=4: Ex_MdOp at cycle t -> MD_Start@t, MD_Busy t+1..t+3, low t+4;
//    Id_MdUse=1 throughout -> stall t+1..t+3, PC_Wr=1 at t+4.
//  5 Ex_MdOp with Mem_BrTaken same cycle -> MD_Start=0, st stays RUN.
//  6 Rst asserted at cnt=2 in BUSY -> next cycle MD_Busy=0, st=RUN, no MD_Start.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock,
// taken-branch flush resolved in MEM, and multi-cycle MUL/DIV tracking.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | MUL/DIV idle; a MUL/DIV op in EX may start a new operation
// BUSY  | MUL/DIV in flight; cnt counts down remaining busy cycles,
//       | ID instructions touching HI/LO are held
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 6
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [4:0] Id_Rs,
  input  logic [4:0] Id_Rt,
  input  logic       Id_UseRs,
  input  logic       Id_UseRt,
  input  logic       Id_MdUse,
  input  logic [1:0] Ex_MemRead,
  input  logic [4:0] Ex_Rw,
  input  logic       Ex_MdOp,
  input  logic       Mem_BrTaken,
  output logic       PC_Wr,
  output logic       IfId_Wr,
  output logic       IfId_Flush,
  output logic       IdEx_Flush,
  output logic       ExMem_Flush,
  output logic       MD_Start,
  output logic       MD_Busy
);

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } st_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  st_t              st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ld_haz;
  logic             md_haz;

  // Hazard detection: load in EX producing a register the ID instruction reads
  // (r0 never creates a dependency), or a HI/LO consumer while MUL/DIV runs.
  always_comb begin
    ld_haz = (Ex_MemRead != 2'b00) && (Ex_Rw != 5'd0) &&
             ((Id_UseRs && (Id_Rs == Ex_Rw)) || (Id_UseRt && (Id_Rt == Ex_Rw)));
    md_haz = (st == BUSY) && Id_MdUse;
  end

  // State register; reset abandons any in-flight MUL/DIV.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      st  <= RUN;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Next state and start pulse. A wrong-path MUL/DIV (branch taken in MEM the
  // same cycle) never starts; a MUL/DIV op seen while BUSY is ignored.
  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    MD_Start = 1'b0;
    if (st == RUN) begin
      if (Ex_MdOp && !Mem_BrTaken && !Rst) begin
        MD_Start = 1'b1;
        st_nxt   = BUSY;
        cnt_nxt  = CNT_LOAD;
      end
    end else begin
      if (cnt == CNT_ONE) begin
        st_nxt  = RUN;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt - CNT_ONE;
      end
    end
  end

  // Pipeline register controls, priority reset > branch > stall > normal.
  // A branch in MEM does not abort BUSY: the MUL/DIV is older than the branch.
  always_comb begin
    PC_Wr       = 1'b1;
    IfId_Wr     = 1'b1;
    IfId_Flush  = 1'b0;
    IdEx_Flush  = 1'b0;
    ExMem_Flush = 1'b0;
    MD_Busy     = (st == BUSY) && !Rst;
    if (Rst) begin
      PC_Wr       = 1'b0;
      IfId_Wr     = 1'b0;
      IfId_Flush  = 1'b1;
      IdEx_Flush  = 1'b1;
      ExMem_Flush = 1'b1;
    end else if (Mem_BrTaken) begin
      IfId_Flush  = 1'b1;
      IdEx_Flush  = 1'b1;
      ExMem_Flush = 1'b1;
    end else if (md_haz || ld_haz) begin
      PC_Wr      = 1'b0;
      IfId_Wr    = 1'b0;
      IdEx_Flush = 1'b1;
    end
  end

endmodule
